// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_t;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency counter: load on grant, decrement while busy, flag the last busy cycle.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mux_2x1.sv
// Generic two-input word multiplexer.
module mux_2x1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and load/store (LS).
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed LS priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The counter holds the remaining BUSY cycles, so it is loaded one short of the latency.
  localparam logic [CNT_W-1:0] LP_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam bit               LP_SINGLE = (MEM_LAT == 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_sel;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_grant;
  logic              w_win;
  logic              w_cnt_tc;
  logic              w_done;
  logic [ADDR_W-1:0] w_mux_addr;
  logic [DATA_W-1:0] w_mux_wdata;

  assign w_grant = reset_n && (r_state == IDLE) && (if_req || ls_req);

`ifdef MEM_ARB_RR_EN
  logic r_last_gnt;

  always_comb begin
    w_win = ls_req;
    if (if_req && ls_req) begin
      w_win = ~r_last_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_gnt <= 1'b0;
    end else if (w_grant) begin
      r_last_gnt <= w_win;
    end
  end
`else
  assign w_win = ls_req;
`endif

  mem_arb_lat_cnt u_lat_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_grant),
    .i_load_val (LP_LOAD),
    .i_dec      (r_state == BUSY),
    .o_tc       (w_cnt_tc)
  );

  // With single-cycle latency the access completes straight from IDLE, never entering BUSY.
  assign w_done = LP_SINGLE ? w_grant : ((r_state == BUSY) && w_cnt_tc);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_grant && !LP_SINGLE) w_next_state = BUSY;
      BUSY: if (w_cnt_tc)              w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  always_comb begin
    if_gnt  = w_grant && (w_win == REQ_IF);
    ls_gnt  = w_grant && (w_win == REQ_LS);
    mem_en  = w_grant;
    mem_we  = w_grant && (w_win == REQ_LS) && ls_we;
    mem_sel = w_grant ? w_win : r_sel;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel       <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
    end else begin
      if (w_grant) r_sel <= w_win;
      r_if_rvalid <= w_done && (mem_sel == REQ_IF);
      r_ls_rvalid <= w_done && (mem_sel == REQ_LS);
    end
  end

  mux_2x1 #(.W(ADDR_W)) u_addr_mux (
    .i_a   (if_addr),
    .i_b   (ls_addr),
    .i_sel (mem_sel),
    .o_y   (w_mux_addr)
  );

  mux_2x1 #(.W(DATA_W)) u_wdata_mux (
    .i_a   ('0),
    .i_b   (ls_wdata),
    .i_sel (mem_sel),
    .o_y   (w_mux_wdata)
  );

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= w_mux_addr;
      r_wdata <= w_mux_wdata;
    end
  end

  assign mem_addr  = (r_state == BUSY) ? r_addr  : w_mux_addr;
  assign mem_wdata = (r_state == BUSY) ? r_wdata : w_mux_wdata;

  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 second instance).
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] IF_A = 32'h0040_0000;
  localparam logic [31:0] LS_A = 32'h1001_0000;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_sel, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        d1_if_req, d1_ls_req, d1_ls_we;
  logic [31:0] d1_if_addr, d1_ls_addr, d1_ls_wdata;
  logic        d1_if_gnt, d1_if_rvalid, d1_ls_gnt, d1_ls_rvalid;
  logic [31:0] d1_if_rdata, d1_ls_rdata;
  logic        d1_mem_sel, d1_mem_en, d1_mem_we;
  logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(d1_if_req), .if_addr(d1_if_addr), .if_gnt(d1_if_gnt), .if_rvalid(d1_if_rvalid),
    .if_rdata(d1_if_rdata),
    .ls_req(d1_ls_req), .ls_we(d1_ls_we), .ls_addr(d1_ls_addr), .ls_wdata(d1_ls_wdata),
    .ls_gnt(d1_ls_gnt), .ls_rvalid(d1_ls_rvalid), .ls_rdata(d1_ls_rdata),
    .mem_sel(d1_mem_sel), .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
  );

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return a ^ 32'hA5C3_3C5A;
  endfunction

  // Memory models: read data for an address appears exactly the latency after it was presented.
  logic [31:0] m0_a1, m0_a2, m1_a1;
  always @(posedge clk) begin
    m0_a1 <= mem_addr;
    m0_a2 <= m0_a1;
    m1_a1 <= d1_mem_addr;
  end
  assign mem_rdata    = fmem(m0_a2);
  assign d1_mem_rdata = fmem(m1_a1);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_sel}
  function automatic logic [6:0] ctrl0();
    return {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_sel};
  endfunction

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = IF_A; ls_addr = LS_A; ls_wdata = WD;
    d1_if_req = 0; d1_ls_req = 0; d1_ls_we = 0;
    d1_if_addr = 0; d1_ls_addr = 0; d1_ls_wdata = 0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset(input bit check_state);
    reset_n = 0;
    idle_inputs();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      chk("reset_ctrl", ctrl0(), 7'b0);
      chk("reset_ctrl_lat1", {d1_if_gnt, d1_if_rvalid, d1_mem_en, d1_mem_sel}, 4'b0);
    end
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  typedef struct {
    logic ir, lr, we;
    logic eig, elg, eir, elr, esel, lchk;
  } vec_t;

  vec_t vecs[11];

  // Random-run reference model state
  typedef struct {
    int          due;
    bit          owner;
    bit          we;
    logic [31:0] addr;
  } acc_t;
  acc_t q[$];

  initial begin
    // Directed cycle table: IF-only, tie (load), then store.
    vecs[0]  = '{1,0,0, 1,0,0,0,0, 0};
    vecs[1]  = '{0,0,0, 0,0,0,0,0, 0};
    vecs[2]  = '{0,0,0, 0,0,1,0,0, 0};
    vecs[3]  = '{1,1,0, 0,1,0,0,1, 0};
    vecs[4]  = '{1,0,0, 0,0,0,0,1, 0};
    vecs[5]  = '{1,0,0, 1,0,0,1,0, 1};
    vecs[6]  = '{0,0,0, 0,0,0,0,0, 0};
    vecs[7]  = '{0,0,0, 0,0,1,0,0, 0};
    vecs[8]  = '{0,1,1, 0,1,0,0,1, 0};
    vecs[9]  = '{0,0,0, 0,0,0,0,1, 0};
    vecs[10] = '{0,0,0, 0,0,0,1,1, 0};

    do_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      if_req = vecs[i].ir; ls_req = vecs[i].lr; ls_we = vecs[i].we;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), ctrl0(),
          {vecs[i].eig, vecs[i].elg, vecs[i].eir, vecs[i].elr,
           vecs[i].eig | vecs[i].elg, vecs[i].elg & vecs[i].we, vecs[i].esel});
      if (vecs[i].eig) chk($sformatf("vec%0d_addr", i), mem_addr, IF_A);
      if (vecs[i].elg) chk($sformatf("vec%0d_addr", i), mem_addr, LS_A);
      if (vecs[i].elg && vecs[i].we) chk($sformatf("vec%0d_wdata", i), mem_wdata, WD);
      if (vecs[i].eir) chk($sformatf("vec%0d_if_rdata", i), if_rdata, fmem(IF_A));
      if (vecs[i].lchk) chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, fmem(LS_A));
      @(posedge clk); #1;
    end

    // Continuous contention: both requesters held high across 8 grants.
    do_reset(1'b0);
    if_req = 1; ls_req = 1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_g;
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      chk($sformatf("tie_gnt%0d", k), {if_gnt, ls_gnt}, exp_g);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tie_busy%0d", k), {if_gnt, ls_gnt}, 2'b00);
      @(posedge clk); #1;
    end

    // Reset in the middle of a BUSY access.
    do_reset(1'b0);
    if_req = 1;
    @(negedge clk);
    chk("rst_mid_gnt", {if_gnt, mem_en}, 2'b11);
    @(posedge clk); #1;
    if_req = 1; ls_req = 1; reset_n = 0;
    @(negedge clk);
    chk("rst_mid_busy", {if_gnt, ls_gnt, mem_en}, 3'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_t2", ctrl0(), 7'b0);
    @(posedge clk); #1;
    reset_n = 1; if_req = 0; ls_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_norv%0d", k), {if_rvalid, ls_rvalid}, 2'b00);
      @(posedge clk); #1;
    end

    // Single-cycle latency instance: IF streams with no bubble.
    do_reset(1'b0);
    begin
      logic [31:0] prev_a;
      d1_if_req = 1; d1_if_addr = 32'h0000_1000; prev_a = '0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk($sformatf("lat1_gnt%0d", k), {d1_if_gnt, d1_mem_sel, d1_mem_addr},
            {1'b1, 1'b0, d1_if_addr});
        chk($sformatf("lat1_rv%0d", k), d1_if_rvalid, (k >= 1));
        if (k >= 1) chk($sformatf("lat1_rdata%0d", k), d1_if_rdata, fmem(prev_a));
        @(posedge clk); #1;
        prev_a = d1_if_addr;
        d1_if_addr = d1_if_addr + 32'd4;
      end
      d1_if_req = 0;
    end

    // Randomized traffic against the reference model.
    do_reset(1'b0);
    begin
      int  free_at;
      bit  m_last, g_if, g_ls;
      q.delete();
      free_at = 0; m_last = 0; g_if = 0; g_ls = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [6:0]  e;
        logic [31:0] e_addr;
        bit          e_gnt, win, rv_if, rv_ls, rv_ld;
        logic [31:0] rv_addr;
        if (!if_req || g_if) begin
          if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
        end
        if (!ls_req || g_ls) begin
          ls_req = ($urandom_range(0, 2) != 0); ls_addr = $urandom;
          ls_we = $urandom_range(0, 1); ls_wdata = $urandom;
        end
        @(negedge clk);
        rv_if = 0; rv_ls = 0; rv_ld = 0; rv_addr = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          acc_t a;
          a = q.pop_front();
          rv_if = (a.owner == 0); rv_ls = (a.owner == 1);
          rv_ld = (a.owner == 1) && !a.we; rv_addr = a.addr;
        end
        e_gnt = (cyc >= free_at) && (if_req || ls_req);
        win = 0; g_if = 0; g_ls = 0; e_addr = '0;
        if (e_gnt) begin
`ifdef MEM_ARB_RR_EN
          win = (if_req && ls_req) ? ~m_last : ls_req;
`else
          win = ls_req;
`endif
          e_addr = win ? ls_addr : if_addr;
          q.push_back('{cyc + LAT, win, win && ls_we, e_addr});
          free_at = cyc + LAT;
          m_last = win;
          g_if = !win; g_ls = win;
        end
        e = {g_if, g_ls, rv_if, rv_ls, e_gnt, g_ls && ls_we, m_last};
        chk($sformatf("rnd%0d_ctrl", cyc), ctrl0(), e);
        if (e_gnt) chk($sformatf("rnd%0d_addr", cyc), mem_addr, e_addr);
        if (g_ls && ls_we) chk($sformatf("rnd%0d_wdata", cyc), mem_wdata, ls_wdata);
        if (rv_if) chk($sformatf("rnd%0d_if_rdata", cyc), if_rdata, fmem(rv_addr));
        if (rv_ld) chk($sformatf("rnd%0d_ls_rdata", cyc), ls_rdata, fmem(rv_addr));
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
